host_bus_master: RTL and testbench

HOST_BUS_MASTER -- requirements
Module: host_bus_master

---
 rtl/host_bus_master_if.sv | 36 +++
 rtl/host_bus_master.sv | 131 +++++++++++++
 tb/tb_host_bus_master.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_bus_master_if.sv
// host_bus_master_if
//   Groups the request/response handshake and the host debug bus pins of
//   host_bus_master. Clock and reset are plain ports on the master.
//   master modport: used by the initiator (host_bus_master).
//   slave modport : used by whatever drives requests and models the responder.
//   Request side : req_valid, req_ready, req_write, req_addr[6:1], req_wdata
//   Response side: rsp_valid (one-cycle pulse), rsp_rdata, busy
//   Bus side     : host_addr, host_data_out, host_data_in, host_ncs/nwe/nre
interface host_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [5:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic [5:0]  host_addr;
    logic [15:0] host_data_out;
    logic [15:0] host_data_in;
    logic        host_ncs;
    logic        host_nwe;
    logic        host_nre;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, host_data_in,
        output req_ready, rsp_valid, rsp_rdata, busy,
               host_addr, host_data_out, host_ncs, host_nwe, host_nre
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, host_data_in,
        input  req_ready, rsp_valid, rsp_rdata, busy,
               host_addr, host_data_out, host_ncs, host_nwe, host_nre
    );
endinterface

// File: rtl/host_bus_master.sv
// host_bus_master
//   Initiator for the host debug bus. Turns one accepted valid/ready request
//   into a chip-select framed cycle: SETUP (ncs low), STROBE (nwe or nre low),
//   HOLD (ncs low, strobes high), then back to IDLE with a one-cycle rsp_valid.
//   Ports:
//     clk    - system clock, all state changes on the rising edge
//     reset  - synchronous, active-high; aborts any transaction in flight
//     bus    - host_bus_master_if.master (request, response and bus pins)
//
//   state  | meaning
//   IDLE   | ready for a request; ncs high; rsp_valid pulses on first cycle here
//   SETUP  | ncs low, address/data presented, strobes high
//   STROBE | ncs low, nwe (write) or nre (read) low
//   HOLD   | ncs low, strobes high, address/data still held
module host_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              reset,
    host_bus_master_if.master bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // Phase counter loads N-1 and the phase ends on the edge where it reads 0.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic        r_ncs;
    logic        r_nwe;
    logic        r_nre;
    logic [5:0]  r_addr;
    logic [15:0] r_dout;
    logic [15:0] r_rdata;
    logic        r_rsp_valid;
    logic        r_busy;

    logic        w_ready;
    logic        w_cnt_done;

    assign w_ready    = (r_state == ST_IDLE) && !reset;
    assign w_cnt_done = (r_cnt == 4'd0);

    // The bus pins are registered one edge ahead of the state they belong to,
    // so the flops themselves drive the pins with no decode in between.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_ncs       <= 1'b1;
            r_nwe       <= 1'b1;
            r_nre       <= 1'b1;
            r_addr      <= 6'd0;
            r_dout      <= 16'h0000;
            r_rdata     <= 16'h0000;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_state <= ST_SETUP;
                        r_cnt   <= SETUP_LD;
                        r_write <= bus.req_write;
                        r_ncs   <= 1'b0;
                        r_addr  <= bus.req_addr;
                        r_dout  <= bus.req_write ? bus.req_wdata : 16'h0000;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (w_cnt_done) begin
                        r_state <= ST_STROBE;
                        r_cnt   <= STROBE_LD;
                        r_nwe   <= !r_write;
                        r_nre   <= r_write;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_STROBE: begin
                    if (w_cnt_done) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= HOLD_LD;
                        r_nwe   <= 1'b1;
                        r_nre   <= 1'b1;
                        if (!r_write) begin
                            r_rdata <= bus.host_data_in;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    if (w_cnt_done) begin
                        r_state     <= ST_IDLE;
                        r_ncs       <= 1'b1;
                        r_addr      <= 6'd0;
                        r_dout      <= 16'h0000;
                        r_busy      <= 1'b0;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready     = w_ready;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_rdata     = r_rdata;
    assign bus.busy          = r_busy;
    assign bus.host_addr     = r_addr;
    assign bus.host_data_out = r_dout;
    assign bus.host_ncs      = r_ncs;
    assign bus.host_nwe      = r_nwe;
    assign bus.host_nre      = r_nre;

endmodule

// File: tb/tb_host_bus_master.sv
// tb_host_bus_master
//   Two instances: u_dut1 with default timing (1/2/1) and u_dut2 with 3/4/2.
//   sel picks which instance receives req_valid and which one is observed.
//   Expected waveforms come from the per-cycle timing rules: cycle k after
//   the acceptance edge is SETUP for k<=S, STROBE for S<k<=S+T, HOLD up to
//   S+T+H, and the response cycle at S+T+H+1.
module tb_host_bus_master;

    logic        clk;
    logic        tb_reset;
    logic        sel;
    logic        tb_valid;
    logic        tb_write;
    logic [5:0]  tb_addr;
    logic [15:0] tb_wdata;
    logic [15:0] tb_hdi;

    int n_checks;
    int n_errors;
    logic [15:0] exp_rd [2];

    host_bus_master_if bus1();
    host_bus_master_if bus2();

    assign bus1.req_valid    = tb_valid & ~sel;
    assign bus2.req_valid    = tb_valid & sel;
    assign bus1.req_write    = tb_write;
    assign bus2.req_write    = tb_write;
    assign bus1.req_addr     = tb_addr;
    assign bus2.req_addr     = tb_addr;
    assign bus1.req_wdata    = tb_wdata;
    assign bus2.req_wdata    = tb_wdata;
    assign bus1.host_data_in = tb_hdi;
    assign bus2.host_data_in = tb_hdi;

    host_bus_master u_dut1 (
        .clk   (clk),
        .reset (tb_reset),
        .bus   (bus1)
    );

    host_bus_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)) u_dut2 (
        .clk   (clk),
        .reset (tb_reset),
        .bus   (bus2)
    );

    // {ready, busy, rsp_valid, ncs, nwe, nre, addr[5:0], dout[15:0], rdata[15:0]}
    logic [43:0] obs;
    logic [43:0] obs1;
    logic [43:0] obs2;
    assign obs1 = {bus1.req_ready, bus1.busy, bus1.rsp_valid, bus1.host_ncs,
                   bus1.host_nwe, bus1.host_nre, bus1.host_addr,
                   bus1.host_data_out, bus1.rsp_rdata};
    assign obs2 = {bus2.req_ready, bus2.busy, bus2.rsp_valid, bus2.host_ncs,
                   bus2.host_nwe, bus2.host_nre, bus2.host_addr,
                   bus2.host_data_out, bus2.rsp_rdata};
    assign obs  = sel ? obs2 : obs1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // One transaction on the selected instance, starting at the negedge of
    // the acceptance cycle (cycle 0). Ends at the negedge of the response
    // cycle, or right after a reset abort when abort_at is nonzero.
    task automatic run_txn(input bit wr, input logic [5:0] a, input logic [15:0] d,
                           input logic [15:0] rv, input bit hold, input int abort_at,
                           input string tag);
        int s = sel ? 3 : 1;
        int t = sel ? 4 : 2;
        int h = sel ? 2 : 1;
        int n = s + t + h;
        logic [15:0] old_rd = exp_rd[sel];
        logic [43:0] exp;
        bit in_txn;
        bit strobe;
        tb_valid = 1'b1;
        tb_write = wr;
        tb_addr  = a;
        tb_wdata = d;
        tb_hdi   = 16'($urandom);
        n_checks++;
        if (obs[43] !== 1'b1) begin
            n_errors++;
            $display("FAIL %s accept: req_ready got %b want 1", tag, obs[43]);
        end
        for (int k = 1; k <= n + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            in_txn = (k <= n);
            strobe = (k > s) && (k <= s + t);
            exp = {!in_txn, in_txn, (k == n + 1), !in_txn,
                   !(strobe && wr), !(strobe && !wr),
                   in_txn ? a : 6'd0,
                   (in_txn && wr) ? d : 16'h0000,
                   (!wr && k > s + t) ? rv : old_rd};
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL %s cycle%0d: got %h want %h", tag, k, obs, exp);
            end
            if (k == abort_at) begin
                tb_reset = 1'b1;
                tb_valid = 1'b0;
                @(posedge clk);
                @(negedge clk);
                exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0, 16'h0000, 16'h0000};
                n_checks++;
                if (obs !== exp) begin
                    n_errors++;
                    $display("FAIL %s abort: got %h want %h", tag, obs, exp);
                end
                tb_reset = 1'b0;
                exp_rd[0] = 16'h0000;
                exp_rd[1] = 16'h0000;
                for (int j = 0; j < 3; j++) begin
                    @(posedge clk);
                    @(negedge clk);
                    exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0, 16'h0000, 16'h0000};
                    n_checks++;
                    if (obs !== exp) begin
                        n_errors++;
                        $display("FAIL %s post_abort%0d: got %h want %h", tag, j, obs, exp);
                    end
                end
                return;
            end
            if (!hold) tb_valid = 1'b0;
            tb_write = 1'($urandom);
            tb_addr  = 6'($urandom);
            tb_wdata = 16'($urandom);
            tb_hdi   = strobe ? rv : 16'($urandom);
        end
        if (!wr) exp_rd[sel] = rv;
    endtask

    task automatic idle_cycles(input int cnt, input string tag);
        logic [43:0] exp;
        for (int j = 0; j < cnt; j++) begin
            @(posedge clk);
            @(negedge clk);
            exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0, 16'h0000, exp_rd[sel]};
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL %s idle%0d: got %h want %h", tag, j, obs, exp);
            end
        end
    endtask

    task automatic test_reset();
        logic [43:0] exp;
        tb_reset = 1'b1;
        tb_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(posedge clk);
            @(negedge clk);
            exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0, 16'h0000, 16'h0000};
            n_checks++;
            if (obs1 !== exp) begin
                n_errors++;
                $display("FAIL reset_dut1_%0d: got %h want %h", j, obs1, exp);
            end
            n_checks++;
            if (obs2 !== exp) begin
                n_errors++;
                $display("FAIL reset_dut2_%0d: got %h want %h", j, obs2, exp);
            end
        end
        tb_reset = 1'b0;
        exp_rd[0] = 16'h0000;
        exp_rd[1] = 16'h0000;
        #1;
        n_checks++;
        if (bus1.req_ready !== 1'b1 || bus2.req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_ready: got %b%b want 11", bus1.req_ready, bus2.req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_write();
        run_txn(1'b1, 6'h05, 16'hA5C3, 16'h0000, 1'b0, 0, "write");
        idle_cycles(1, "write");
    endtask

    task automatic test_read();
        run_txn(1'b0, 6'h02, 16'hFFFF, 16'h1234, 1'b0, 0, "read");
        n_checks++;
        if (bus1.rsp_rdata !== 16'h1234) begin
            n_errors++;
            $display("FAIL read_rdata: got %h want 1234", bus1.rsp_rdata);
        end
        idle_cycles(1, "read");
        run_txn(1'b1, 6'h3F, 16'h0F0F, 16'h0000, 1'b0, 0, "write_keeps_rdata");
        idle_cycles(1, "write_keeps_rdata");
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 6'h11, 16'hBEEF, 16'h0000, 1'b1, 0, "b2b_first");
        run_txn(1'b0, 6'h22, 16'h0000, 16'hC0DE, 1'b0, 0, "b2b_second");
        idle_cycles(1, "b2b");
    endtask

    task automatic test_abort();
        run_txn(1'b0, 6'h0A, 16'h0000, 16'h7E57, 1'b0, 0, "pre_abort_read");
        run_txn(1'b0, 6'h02, 16'h0000, 16'h1234, 1'b0, 2, "abort_read_c2");
        run_txn(1'b1, 6'h15, 16'h9999, 16'h0000, 1'b0, 4, "abort_write_hold");
    endtask

    task automatic test_random();
        bit wr;
        bit hold;
        for (int i = 0; i < 24; i++) begin
            wr   = 1'($urandom);
            hold = (i < 23) ? 1'($urandom) : 1'b0;
            run_txn(wr, 6'($urandom), 16'($urandom), 16'($urandom), hold, 0, "random");
            if (!hold) idle_cycles(int'($urandom_range(0, 2)), "random");
        end
    endtask

    task automatic test_params();
        sel = 1'b1;
        #1;
        run_txn(1'b1, 6'h2A, 16'h5AA5, 16'h0000, 1'b0, 0, "param_write");
        idle_cycles(1, "param_write");
        run_txn(1'b0, 6'h31, 16'h0000, 16'h8421, 1'b1, 0, "param_read");
        run_txn(1'b1, 6'($urandom), 16'($urandom), 16'h0000, 1'b0, 0, "param_b2b");
        idle_cycles(2, "param");
        sel = 1'b0;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        sel      = 1'b0;
        tb_reset = 1'b1;
        tb_valid = 1'b0;
        tb_write = 1'b0;
        tb_addr  = 6'd0;
        tb_wdata = 16'h0000;
        tb_hdi   = 16'h0000;
        exp_rd[0] = 16'h0000;
        exp_rd[1] = 16'h0000;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_abort();
        test_random();
        test_params();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
